// File: rtl/ram_if_pkg.sv
// Shared constants and state encoding for the RAM burst master.
package ram_if_pkg;

  localparam int unsigned RAM_DEPTH  = 512;
  localparam int unsigned ADDR_W_DEF = $clog2(RAM_DEPTH);
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_TURN  = 2'd3
  } state_e;

endpackage

// File: rtl/ram_burst_master_if.sv
// Command, write-stream and read-stream port of the RAM burst master.
interface ram_burst_master_if #(
  parameter int unsigned ADDR_W = ram_if_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = ram_if_pkg::DATA_W_DEF
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              busy;

  // Burst master side
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready,
    output cmd_ready, wr_ready, rd_data, rd_valid, busy
  );

  // Requesting client side
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready,
    input  cmd_ready, wr_ready, rd_data, rd_valid, busy
  );

endinterface

// File: rtl/ram_burst_master.sv
// Burst sequencer for a single-port RAM with level-sensitive re/we and a shared data bus.
module ram_burst_master #(
  parameter int unsigned ADDR_W = ram_if_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = ram_if_pkg::DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  ram_burst_master_if.master     bus,
  output logic                   ram_re,
  output logic                   ram_we,
  output logic [ADDR_W-1:0]      ram_addr,
  inout  wire  [DATA_W-1:0]      ram_data
);
  import ram_if_pkg::*;

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] WRITE = ST_WRITE;
  localparam logic [1:0] READ  = ST_READ;
  localparam logic [1:0] TURN  = ST_TURN;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic              wr_done_q, wr_done_d;
  logic              re_d, we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  // Handshake ready/busy decode straight from state
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.wr_ready  = (state_q == WRITE) && !wr_done_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;

  // Data bus is driven only during a registered write cycle
  assign ram_data = ram_we ? wdata_q : {DATA_W{1'bz}};

  // Next-state and next-output decode
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    wr_done_d   = wr_done_q;
    re_d        = 1'b0;
    we_d        = 1'b0;
    addr_d      = ram_addr;
    wdata_d     = wdata_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_valid_q && !bus.rd_ready;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          cur_addr_d  = bus.cmd_addr;
          remaining_d = bus.cmd_len;
          wr_done_d   = 1'b0;
          if (bus.cmd_write) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
            re_d    = 1'b1;
            addr_d  = bus.cmd_addr;
          end
        end
      end

      WRITE: begin
        // Last word sits on the bus for one more cycle before turnaround
        if (wr_done_q) begin
          state_d   = TURN;
          wr_done_d = 1'b0;
        end else if (bus.wr_valid) begin
          we_d        = 1'b1;
          wdata_d     = bus.wr_data;
          addr_d      = cur_addr_q;
          cur_addr_d  = cur_addr_q + ADDR_W'(1);
          remaining_d = remaining_q - ADDR_W'(1);
          if (remaining_q == '0) begin
            wr_done_d = 1'b1;
          end
        end
      end

      READ: begin
        re_d = 1'b1;
        // Capture only when the output slot is free; otherwise re-read the same address
        if (!rd_valid_q || bus.rd_ready) begin
          rd_data_d  = ram_data;
          rd_valid_d = 1'b1;
          if (remaining_q == '0) begin
            re_d    = 1'b0;
            state_d = TURN;
          end else begin
            cur_addr_d  = cur_addr_q + ADDR_W'(1);
            addr_d      = cur_addr_q + ADDR_W'(1);
            remaining_d = remaining_q - ADDR_W'(1);
          end
        end
      end

      TURN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      wr_done_q   <= 1'b0;
      ram_re      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      wdata_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      wr_done_q   <= wr_done_d;
      ram_re      <= re_d;
      ram_we      <= we_d;
      ram_addr    <= addr_d;
      wdata_q     <= wdata_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

endmodule

// File: doc/ram_burst_master.md
# ram_burst_master

Bus master for the single-port 512×32 RAM, which has level-sensitive `re`/`we`, a 9-bit address and a bidirectional 32-bit data bus. It accepts burst commands on a valid/ready port, sequences the RAM control lines, streams write words in, and streams read words out. It never asserts `re` and `we` together. It drives the data bus only while writing.

## Interface
- `ADDR_W`, 9, RAM address width
- `DATA_W`, 32, RAM data width

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when both high at an edge; high only in IDLE
- `cmd_write`  in  1  1 = write burst, 0 = read burst
- `cmd_addr`  in  ADDR_W  start address
- `cmd_len`  in  ADDR_W  burst length minus one (0..511 → 1..512 words)
- `wr_data`  in  DATA_W  write word
- `wr_valid`  in  1  write word offered
- `wr_ready`  out  1  write word accepted
- `rd_data`  out  DATA_W  read word
- `rd_valid`  out  1  read word present
- `rd_ready`  in  1  consumer takes the read word
- `busy`  out  1  state ≠ IDLE
- `ram_re`  out  1  RAM output enable
- `ram_we`  out  1  RAM write enable
- `ram_addr`  out  ADDR_W  RAM address
- `ram_data`  inout  DATA_W  driven with the write register while `ram_we`=1, otherwise high-Z

## Operation
- States: IDLE, WRITE, READ, TURN.
- IDLE:
  - `cmd_ready`=1.
  - On a command handshake: latch `cur_addr`=`cmd_addr` and `remaining`=`cmd_len`.
  - Go to WRITE or READ.
- WRITE:
  - `wr_ready`=1.
  - Each `wr_valid` handshake registers the word and address. `ram_we`=1 in the following cycle.
  - With no handshake, `ram_we`=0 in the following cycle and the address is held.
  - After the handshake with `remaining`=0, go to TURN.
- READ:
  - `ram_re`=1 with `ram_addr`=`cur_addr`.
  - At each edge where `!rd_valid || rd_ready`: capture `ram_data` into `rd_data`, set `rd_valid`=1, and advance.
  - Otherwise hold `ram_re` and the address. Rereads are harmless.
  - After capturing with `remaining`=0, drop `ram_re` and go to TURN.
- TURN: one cycle with `re`=`we`=0 and the bus at Z. Then go to IDLE.
- `rd_valid` clears on `rd_ready` when no new capture occurs, in any state.
- Address arithmetic is modulo 2^ADDR_W: 511 + 1 = 0, with no error.
- `ram_re` && `ram_we` is never 1.
- The bus is never driven while `ram_we`=0.
- Reset mid-burst:
  - The burst is abandoned and the next state is IDLE.
  - The write in progress is dropped, and `rd_valid` clears.
  - No partial-cycle glitch on `re`/`we`, because both are registered.

## Timing
- Reset values:
  - `cmd_ready`=1, `busy`=0, `wr_ready`=0.
  - `rd_valid`=0, `rd_data`=0.
  - `ram_re`=0, `ram_we`=0, `ram_addr`=0, `ram_data`=Z.
- All outputs except `cmd_ready`, `busy` and `wr_ready` are registered. Those three decode from state.
- Write burst of N words, with `wr_valid` held high and the command accepted at edge 0:
  - Handshakes at edges 1..N.
  - `ram_we` high in cycles 1..N, each word at successive addresses.
  - TURN in cycle N+1; `cmd_ready` high in cycle N+2.
- Read burst of N words, with `rd_ready` held high and the command accepted at edge 0:
  - `ram_re` high in cycles 0..N-1.
  - Word k is valid on `rd_data` in cycle k+1.
  - TURN in cycle N; `cmd_ready` in cycle N+1.
- Read latency: address to `rd_data` is 1 cycle, since the RAM read is combinational within the cycle.
- Throughput: one word per cycle when not stalled.

## Structure
- Package `ram_if_pkg`:
  - `ADDR_W`/`DATA_W` defaults.
  - State enum (IDLE, WRITE, READ, TURN).
  - `RAM_DEPTH`=512.
- Single module. The tri-state assign lives in the top. No sub-module is warranted.

## Test plan
- Write 1, 2, 4, 8, 16 to addresses 0..4 (`cmd_addr`=0, `cmd_len`=4) → `ram_we` pulses cycles 1..5, RAM holds 1/2/4/8/16; then read 0..4 → `rd_data` 1, 2, 4, 8, 16 in cycles 1..5.
- Read burst at `cmd_addr`=510, `cmd_len`=3 → `ram_addr` sequence 510, 511, 0, 1; four words returned.
- Read burst of 4 with `rd_ready` low for 3 cycles after the first word → `ram_addr` held, no word lost or duplicated, `busy` extended by 3 cycles.
- Write burst of 3 with `wr_valid` gapped (1, 0, 1, 0, 1) → `ram_we` high only in the cycles after handshakes; addresses 0, 1, 2.
- `rst` asserted in the middle of a 10-word write → next cycle: `ram_we`=0, bus Z, `cmd_ready`=1; the remaining addresses are unmodified.
- Assertion across all tests: never `ram_re` && `ram_we`; `ram_data` is Z whenever `ram_we`=0.
